ifu: RTL

Instruction fetch unit for the single-issue RV32I core. It owns the program counter, issues word fetches to instruction memory over a request/grant/response interface, and buffers returned instructions in a small in-order FIFO. It presents them with their addresses to the if_id pipeline register, which feeds the decode stage. Redirects from the execute stage flush the buffer and drop in-flight responses.

---
 rtl/ifu.sv | 130 +++++++++++++
 1 files changed

// File: rtl/ifu.sv
// ifu: instruction fetch unit for the single-issue RV32I core.
// Owns the program counter, issues word fetches over a req/gnt/rvalid
// instruction-memory interface and buffers in-order responses in a small
// prefetch FIFO that feeds the if_id pipeline register.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req_o/imem_addr_o   fetch request and word-aligned address
//   imem_gnt_i               request accepted this cycle
//   imem_rvalid_i/rdata_i    in-order instruction response
//   jump_en_i/jump_addr_i    redirect from execute; flushes the buffer
//   inst_ready_i             downstream accepts the head instruction
//   inst_valid_o/inst_o/inst_addr_o  head instruction (NOP/0 when invalid)
module ifu #(
  parameter int unsigned DEPTH      = 4,
  parameter logic [31:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        inst_ready_i,
  output logic        inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o
);

  localparam int unsigned   AW      = $clog2(DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [AW+1:0] DEPTH_W = (AW+2)'(DEPTH);

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [AW:0]   r_inflight;
  logic [AW:0]   r_discard;
  logic [AW:0]   r_count;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_fifo_addr [DEPTH];
  logic [31:0]   r_fifo_inst [DEPTH];

  logic          w_pop;
  logic          w_gnt;
  logic          w_push;
  logic [AW+1:0] w_credit;
  logic [31:0]   w_jump_tgt;

  assign w_jump_tgt = jump_addr_i & ~32'h0000_0003;

  assign inst_valid_o = (r_count != '0) & ~jump_en_i;
  assign inst_o       = inst_valid_o ? r_fifo_inst[r_rd_ptr] : NOP;
  assign inst_addr_o  = inst_valid_o ? r_fifo_addr[r_rd_ptr] : '0;

  assign w_pop = inst_valid_o & inst_ready_i;

  // Outstanding requests plus buffered entries (net of this cycle's pop)
  // must stay below DEPTH so every granted response has a FIFO slot.
  assign w_credit = {1'b0, r_inflight} + {1'b0, r_count}
                  - {{(AW+1){1'b0}}, w_pop};

  assign imem_req_o  = ~rst & ~jump_en_i & (w_credit < DEPTH_W);
  assign imem_addr_o = r_fetch_pc;

  assign w_gnt  = imem_req_o & imem_gnt_i;
  assign w_push = imem_rvalid_i & ~jump_en_i & (r_discard == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_ADDR;
      r_resp_pc  <= RESET_ADDR;
      r_inflight <= '0;
      r_discard  <= '0;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else begin
      r_inflight <= r_inflight + (w_gnt ? CNT_ONE : '0)
                               - (imem_rvalid_i ? CNT_ONE : '0);
      if (jump_en_i) begin
        r_fetch_pc <= w_jump_tgt;
        r_resp_pc  <= w_jump_tgt;
        // inflight already counts responses doomed by earlier jumps, so
        // everything still outstanding after this cycle is to be dropped.
        if (!imem_rvalid_i)
          r_discard <= r_inflight;
        else if (r_inflight != '0)
          r_discard <= r_inflight - CNT_ONE;
        else
          r_discard <= '0;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        if (w_gnt)
          r_fetch_pc <= r_fetch_pc + 32'd4;
        if (imem_rvalid_i) begin
          if (r_discard != '0)
            r_discard <= r_discard - CNT_ONE;
          else
            r_resp_pc <= r_resp_pc + 32'd4;
        end
        if (w_push)
          r_wr_ptr <= r_wr_ptr + PTR_ONE;
        if (w_pop)
          r_rd_ptr <= r_rd_ptr + PTR_ONE;
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + CNT_ONE;
          2'b01:   r_count <= r_count - CNT_ONE;
          default: r_count <= r_count;
        endcase
      end
    end
  end

  // FIFO storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push && !rst) begin
      r_fifo_addr[r_wr_ptr] <= r_resp_pc;
      r_fifo_inst[r_wr_ptr] <= imem_rdata_i;
    end
  end

endmodule
